// File: rtl/alu_arb_pkg.sv
// -----------------------------------------------------------------------------
// alu_arb_pkg
// Shared definitions for the ALU / operand-mux arbiter slice.
//   arb_state_t : arbiter FSM state (IDLE, BUSY, DONE)
//   NREQ        : number of requesters
//   SEL_W       : width of the binary grant index / mux select
//   LOCK_MAX    : maximum consecutive locked re-grants before round-robin resumes
//   CNT_W       : width of the operation latency counter
// -----------------------------------------------------------------------------
package alu_arb_pkg;

   localparam int NREQ     = 4;
   localparam int SEL_W    = 2;
   localparam int LOCK_MAX = 4;
   localparam int CNT_W    = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } arb_state_t;

endpackage

// File: rtl/arb_rr_pick.sv
// -----------------------------------------------------------------------------
// arb_rr_pick
// Combinational rotate-priority picker. Searches req starting one position
// above ptr and wrapping, returning the first set bit.
// Ports:
//   req    in  [NREQ-1:0]  request vector
//   ptr    in  [SEL_W-1:0] index of the most recently granted requester
//   onehot out [NREQ-1:0]  one-hot winner (zero when no request)
//   idx    out [SEL_W-1:0] binary winner index (zero when no request)
//   any    out             at least one request present
// -----------------------------------------------------------------------------
module arb_rr_pick
   import alu_arb_pkg::*;
(
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [3:0] onehot,
   output logic [1:0] idx,
   output logic       any
);

   logic [SEL_W-1:0] cand;

   always_comb begin
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      cand   = '0;
      // Candidate index wraps naturally in SEL_W bits: ptr+1 .. ptr+NREQ.
      for (int k = 1; k <= NREQ; k++) begin
         cand = ptr + SEL_W'(k);
         if (!any && req[cand]) begin
            any = 1'b1;
            idx = cand;
         end
      end
      if (any) begin
         onehot[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/alu_mux_arbiter.sv
// -----------------------------------------------------------------------------
// alu_mux_arbiter
// Round-robin arbiter owning a shared ALU and its 4:1 operand mux. A granted
// requester keeps gnt/sel for OP_LAT+1 cycles: alu_start pulses in the grant
// cycle, done pulses OP_LAT cycles later while gnt is still held. From the
// done cycle a new grant is issued on the next edge without an idle bubble.
//
// Handshake: req[i] is a level request sampled only when the arbiter is free
// (IDLE or the done cycle); once granted the operation always completes with
// exactly one done[i] pulse unless reset intervenes, regardless of req/lock.
//
// Optional feature (macro ARB_LOCK_EN): in the done cycle, if the current
// owner holds lock and req, it is re-granted without moving the round-robin
// pointer, up to LOCK_MAX consecutive times.
//
// Parameters:
//   OP_LAT     ALU latency in cycles, alu_start to done (1..15)
// Ports:
//   clk        in      clock, rising edge
//   rst_n      in      asynchronous active-low reset
//   req        in  [3] per-requester operation request
//   lock       in  [3] per-requester lock request (ARB_LOCK_EN builds only)
//   gnt        out [3] one-hot grant, zero when the ALU is unowned
//   sel        out [1] binary grant index, operand mux select
//   alu_start  out     one-cycle launch pulse
//   done       out [3] one-hot one-cycle completion pulse
//   busy       out     gnt is non-zero
// -----------------------------------------------------------------------------
module alu_mux_arbiter
   import alu_arb_pkg::*;
#(
   parameter int OP_LAT = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic [3:0] lock,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       alu_start,
   output logic [3:0] done,
   output logic       busy
);

   localparam logic [CNT_W-1:0] LAT_C = CNT_W'(OP_LAT);

   arb_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [SEL_W-1:0] ptr;

   logic [3:0]       pick_onehot;
   logic [1:0]       pick_idx;
   logic             pick_any;
   logic             free;
   logic             grant_lock;
   logic             grant_new;

   arb_rr_pick u_pick (
      .req    (req),
      .ptr    (ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   assign free = (state == ST_IDLE) || (state == ST_DONE);

`ifdef ARB_LOCK_EN
   logic [2:0] streak;

   // Re-grant only from the done cycle, and only while the streak budget lasts.
   assign grant_lock = (state == ST_DONE) && lock[sel] && req[sel]
                       && (streak < 3'(LOCK_MAX));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         streak <= '0;
      end else if (grant_lock) begin
         streak <= streak + 3'd1;
      end else if (grant_new) begin
         streak <= '0;
      end
   end
`else
   logic lock_unused;

   assign grant_lock  = 1'b0;
   assign lock_unused = ^lock;
`endif

   assign grant_new = free && pick_any && !grant_lock;
   assign busy      = |gnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         ptr       <= 2'd3;
         gnt       <= '0;
         sel       <= '0;
         alu_start <= 1'b0;
         done      <= '0;
      end else begin
         alu_start <= 1'b0;
         done      <= '0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (grant_lock) begin
                  // Same owner again: gnt, sel and ptr stay as they are.
                  state     <= ST_BUSY;
                  cnt       <= CNT_W'(1);
                  alu_start <= 1'b1;
               end else if (grant_new) begin
                  state     <= ST_BUSY;
                  cnt       <= CNT_W'(1);
                  alu_start <= 1'b1;
                  gnt       <= pick_onehot;
                  sel       <= pick_idx;
                  ptr       <= pick_idx;
               end else begin
                  // sel deliberately keeps its last value while idle.
                  state <= ST_IDLE;
                  gnt   <= '0;
               end
            end
            ST_BUSY: begin
               if (cnt == LAT_C) begin
                  state <= ST_DONE;
                  done  <= gnt;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
               gnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mux_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_mux_arbiter
// Two arbiters share clock, reset and stimulus: instance 0 with OP_LAT=2 and
// instance 1 with OP_LAT=1. A transaction-level model tracks, per instance,
// the edge at which the current operation was granted and derives every
// output from the edge distance to that grant.
// -----------------------------------------------------------------------------
module tb_alu_mux_arbiter;

   localparam int LAT0 = 2;
   localparam int LAT1 = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'b0;
   logic [3:0] lock = 4'b0;

   logic [3:0] gnt0, gnt1, done0, done1;
   logic [1:0] sel0, sel1;
   logic       start0, start1, busy0, busy1;

   logic [11:0] obs [2];
   assign obs[0] = {gnt0, sel0, start0, done0, busy0};
   assign obs[1] = {gnt1, sel1, start1, done1, busy1};

   alu_mux_arbiter #(.OP_LAT(LAT0)) dut0 (
      .clk(clk), .rst_n(rst_n), .req(req), .lock(lock),
      .gnt(gnt0), .sel(sel0), .alu_start(start0), .done(done0), .busy(busy0)
   );

   alu_mux_arbiter #(.OP_LAT(LAT1)) dut1 (
      .clk(clk), .rst_n(rst_n), .req(req), .lock(lock),
      .gnt(gnt1), .sel(sel1), .alu_start(start1), .done(done1), .busy(busy1)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int          checks = 0;
   int          failures = 0;
   int          t = 0;
   bit          m_act [2];
   int          m_g [2];
   logic [1:0]  m_ptr [2];
   logic [1:0]  m_win [2];
   int          m_streak [2];
   logic [11:0] e_obs [2];

   function automatic int lat_of(int d);
      return (d == 0) ? LAT0 : LAT1;
   endfunction

   function automatic logic [1:0] rr_pick(logic [3:0] r, logic [1:0] p);
      int c;
      for (int k = 1; k <= 4; k++) begin
         c = (int'(p) + k) % 4;
         if (r[c]) return c[1:0];
      end
      return p;
   endfunction

   task automatic calc_exp(int d);
      int         lat = lat_of(d);
      bit         on;
      logic [3:0] g = 4'b0;
      on = m_act[d] && (t >= m_g[d]) && (t <= m_g[d] + lat);
      if (on) g[m_win[d]] = 1'b1;
      e_obs[d] = {g, m_win[d], on && (t == m_g[d]),
                  (on && (t == m_g[d] + lat)) ? g : 4'b0, on};
   endtask

   task automatic model_reset(int d);
      m_act[d]    = 1'b0;
      m_g[d]      = 0;
      m_ptr[d]    = 2'd3;
      m_win[d]    = 2'd0;
      m_streak[d] = 0;
      calc_exp(d);
   endtask

   // One rising edge with inputs r/lk sampled.
   task automatic model_step(int d, logic [3:0] r, logic [3:0] lk);
      int lat = lat_of(d);
      bit in_done;
      bit relock = 1'b0;
      if (!(m_act[d] && t <= m_g[d] + lat) && r != 4'b0) begin
         in_done = m_act[d] && (t == m_g[d] + lat + 1);
`ifdef ARB_LOCK_EN
         relock = in_done && lk[m_win[d]] && r[m_win[d]] && (m_streak[d] < 4);
`else
         relock = 1'b0 & in_done & (^lk);
`endif
         if (relock) begin
            m_streak[d]++;
         end else begin
            m_win[d]    = rr_pick(r, m_ptr[d]);
            m_ptr[d]    = m_win[d];
            m_streak[d] = 0;
         end
         m_g[d]   = t;
         m_act[d] = 1'b1;
      end
      calc_exp(d);
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      t++;
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) model_reset(d);
         else        model_step(d, req, lock);
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 4'b0;
      lock  = 4'b0;
      #1;
      for (int d = 0; d < 2; d++) model_reset(d);
      repeat (2) tick();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      req   = 4'b1111;
      #1;
      for (int d = 0; d < 2; d++) model_reset(d);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (obs[d] !== 12'h000) begin
            failures++;
            $display("FAIL reset_state inst%0d got=%h exp=%h", d, obs[d], 12'h000);
         end
      end
      // Requests held through reset must not produce a grant.
      repeat (2) begin
         tick();
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== 12'h000) begin
               failures++;
               $display("FAIL reset_hold inst%0d t=%0d got=%h exp=%h", d, t, obs[d], 12'h000);
            end
         end
      end
      req = 4'b0;
   endtask

   task automatic test_single();
      do_reset();
      req = 4'b0001;
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (k == 1) req = 4'b0000;
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== e_obs[d]) begin
               failures++;
               $display("FAIL single inst%0d t=%0d got=%h exp=%h", d, t, obs[d], e_obs[d]);
            end
         end
         checks++;
         if ((k == 1 && {gnt0, sel0, start0} !== 7'b0001_00_1) ||
             (k == 3 && done0 !== 4'b0001) ||
             (k == 4 && {gnt0, busy0} !== 5'b0)) begin
            failures++;
            $display("FAIL single_timing k=%0d got gnt=%b sel=%0d start=%b done=%b busy=%b",
                     k, gnt0, sel0, start0, done0, busy0);
         end
      end
   endtask

   task automatic test_drop();
      req = 4'b0010;
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (k == 2) req = 4'b0000;
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== e_obs[d]) begin
               failures++;
               $display("FAIL drop inst%0d t=%0d got=%h exp=%h", d, t, obs[d], e_obs[d]);
            end
         end
         checks++;
         if ((k == 3 && done0 !== 4'b0010) || (k == 4 && gnt0 !== 4'b0)) begin
            failures++;
            $display("FAIL drop_done k=%0d got done=%b gnt=%b", k, done0, gnt0);
         end
      end
   endtask

   task automatic test_all_four();
      logic [1:0] exp_q[$];
      logic [1:0] e;
      exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      do_reset();
      req = 4'b1111;
      for (int k = 1; k <= 13; k++) begin
         tick();
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== e_obs[d]) begin
               failures++;
               $display("FAIL all_four inst%0d t=%0d got=%h exp=%h", d, t, obs[d], e_obs[d]);
            end
         end
         checks++;
         if ({start0, |done0} !== {k % 3 == 1, k % 3 == 0}) begin
            failures++;
            $display("FAIL all_four_timing k=%0d got start=%b done=%b", k, start0, done0);
         end
         if (start0) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL all_four_order extra grant sel=%0d", sel0);
            end else begin
               e = exp_q.pop_front();
               if (sel0 !== e) begin
                  failures++;
                  $display("FAIL all_four_order got=%0d exp=%0d", sel0, e);
               end
            end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL all_four_count got_missing=%0d exp=0", exp_q.size());
      end
      req = 4'b0;
   endtask

   task automatic test_oplat1();
      logic [1:0] exp_sel [3];
      exp_sel = '{2'd1, 2'd2, 2'd1};
      do_reset();
      req = 4'b0110;
      for (int k = 1; k <= 6; k++) begin
         tick();
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== e_obs[d]) begin
               failures++;
               $display("FAIL oplat1 inst%0d t=%0d got=%h exp=%h", d, t, obs[d], e_obs[d]);
            end
         end
         checks++;
         if ({start1, |done1} !== {k % 2 == 1, k % 2 == 0} ||
             (k % 2 == 1 && sel1 !== exp_sel[(k - 1) / 2])) begin
            failures++;
            $display("FAIL oplat1_timing k=%0d got start=%b done=%b sel=%0d", k, start1, done1, sel1);
         end
      end
      req = 4'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      req = 4'b0100;
      repeat (2) tick();
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         model_reset(d);
         checks++;
         if (obs[d] !== 12'h000) begin
            failures++;
            $display("FAIL reset_mid inst%0d got=%h exp=%h", d, obs[d], 12'h000);
         end
      end
      req = 4'b0101;
      repeat (3) begin
         tick();
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== e_obs[d]) begin
               failures++;
               $display("FAIL reset_mid_hold inst%0d t=%0d got=%h exp=%h", d, t, obs[d], e_obs[d]);
            end
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (obs[d] !== e_obs[d]) begin
            failures++;
            $display("FAIL reset_mid_regrant inst%0d got=%h exp=%h", d, obs[d], e_obs[d]);
         end
      end
      checks++;
      if ({gnt0, gnt1} !== 8'b0001_0001) begin
         failures++;
         $display("FAIL reset_mid_winner got gnt0=%b gnt1=%b exp=0001", gnt0, gnt1);
      end
      req = 4'b0;
   endtask

   task automatic test_lock();
      logic [1:0] exp_q[$];
      logic [1:0] e;
`ifdef ARB_LOCK_EN
      exp_q = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
`else
      exp_q = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
`endif
      do_reset();
      req  = 4'b0011;
      lock = 4'b0001;
      for (int k = 1; k <= 18; k++) begin
         tick();
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== e_obs[d]) begin
               failures++;
               $display("FAIL lock inst%0d t=%0d got=%h exp=%h", d, t, obs[d], e_obs[d]);
            end
         end
         if (start0) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL lock_order extra grant sel=%0d", sel0);
            end else begin
               e = exp_q.pop_front();
               if (sel0 !== e) begin
                  failures++;
                  $display("FAIL lock_order got=%0d exp=%0d", sel0, e);
               end
            end
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL lock_count got_missing=%0d exp=0", exp_q.size());
      end
      req  = 4'b0;
      lock = 4'b0;
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 400; k++) begin
         req  = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
         lock = 4'($urandom_range(0, 15));
         tick();
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== e_obs[d]) begin
               failures++;
               $display("FAIL random inst%0d t=%0d got=%h exp=%h", d, t, obs[d], e_obs[d]);
            end
         end
      end
      req  = 4'b0;
      lock = 4'b0;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_single();
      test_drop();
      test_all_four();
      test_oplat1();
      test_reset_mid();
      test_lock();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_mux_arbiter.md
ALU_MUX_ARBITER -- requirements
Module: alu_mux_arbiter

Interface
REQ-001 Parameter: OP_LAT, 2, ALU operation latency in cycles from alu_start to result valid, legal range 1..15.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: req  input  4  per-requester operation request, bit i = requester i.
REQ-005 Port: lock  input  4  per-requester lock request; used only when ARB_LOCK_EN is defined.
REQ-006 Port: gnt  output  4  one-hot grant, all-zero when no requester owns the ALU/mux.
REQ-007 Port: sel  output  2  binary-encoded grant index, drives the 4:1 operand mux select.
REQ-008 Port: alu_start  output  1  one-cycle pulse launching the ALU operation.
REQ-009 Port: done  output  4  one-hot one-cycle pulse to the served requester when its result is valid.
REQ-010 Port: busy  output  1  high whenever gnt is non-zero.

Function
REQ-011 FSM states: IDLE, BUSY, DONE; encoded as a package enum.
REQ-012 IDLE: gnt=0, busy=0, alu_start=0, done=0; sel holds its last value.
REQ-013 IDLE with req!=0 sampled at edge N: at N+1 gnt=one-hot winner, sel=winner index, alu_start=1, state=BUSY, latency counter loaded with 1.
REQ-014 Winner: first set req bit searching from (ptr+1) mod 4 upward with wrap; ptr = last granted index.
REQ-015 ptr updates to the winner index in the grant cycle.
REQ-016 BUSY: gnt and sel stable; alu_start=0; req/lock changes ignored; counter increments each cycle.
REQ-017 When the counter equals OP_LAT, move to DONE; done[winner]=1 for exactly the cycle OP_LAT after alu_start; gnt stays asserted in that cycle.
REQ-018 DONE with req!=0: next cycle issues a new grant per REQ-013/014 directly (no IDLE bubble); with req=0: next cycle IDLE.
REQ-019 Throughput: one operation per OP_LAT+1 cycles under continuous requests.
REQ-020 Deasserting req[winner] during BUSY does not abort the operation; done is still pulsed.
REQ-021 Requests from all four simultaneously: served 0,1,2,3,0,... after reset.
REQ-022 Counter width 4 bits; no wrap occurs within the legal OP_LAT range.

Reset
REQ-023 rst_n low: gnt=0, done=0, alu_start=0, busy=0, sel=0, state=IDLE, counter=0, ptr=3, lock-streak=0, all immediately.
REQ-024 Reset mid-operation discards the operation; no done pulse is ever issued for it.
REQ-025 First grant is evaluated no earlier than the first rising edge after rst_n deasserts.

Configuration
REQ-026 Macro ARB_LOCK_EN: when defined, in DONE with lock[winner]&&req[winner], the same requester is re-granted, ptr unchanged, lock-streak incremented.
REQ-027 With ARB_LOCK_EN, after 4 consecutive locked re-grants the next grant follows REQ-014 regardless of lock; lock-streak clears on any non-locked grant.
REQ-028 Without ARB_LOCK_EN: lock port present but ignored; no lock-streak register synthesised; pure round-robin.

Structure
REQ-029 Package alu_arb_pkg holds: state enum, NREQ=4, SEL_W=2, LOCK_MAX=4.
REQ-030 Sub-module arb_rr_pick: combinational rotate-priority picker (req, ptr -> one-hot, index, any).

Verification (OP_LAT=2 unless noted)
REQ-031 req=0001 at edge 0 -> gnt=0001, sel=00, alu_start=1 at edge 1; done=0001 at edge 3; IDLE at edge 4 with req=0.
REQ-032 req=1111 held -> grants 0,1,2,3,0 at edges 1,4,7,10,13; done pulses at 3,6,9,12.
REQ-033 OP_LAT=1, req=0110 held -> grants 1,2,1 at edges 1,3,5; done at 2,4.
REQ-034 rst_n low at edge 2 during BUSY for requester 2 -> all outputs 0 immediately; no done; next grant after release goes to requester 0 if req=0101.
REQ-035 ARB_LOCK_EN, req=0011, lock=0001 held -> requester 0 granted 5 times in a row, then requester 1.
REQ-036 req[winner] dropped at edge 2 -> done still pulsed at edge 3 and gnt released.
